rv_hart_sched: RTL and testbench
================================

// Module: rv_hart_sched
// PURPOSE
//  Dynamic hart scheduler for the barrel pipeline; replaces the static timer-indexed hart table.
//  Each cycle issues at most one hart slot {valid, hart_id} into the hart shift chain / PC stage.
//  Picks round-robin among runnable harts, never re-issuing a hart still in flight, inserting bubbles otherwise.
//  Run mask is set/cleared by wake/park pulses (CSR-driven) so software can start and stop harts.
// PARAMETERS
//  NUM_HARTS   8     number of hardware harts (power of 2, 2..8)
//  HART_W      3     hart id width, = clog2(NUM_HARTS)
//  PIPE_DEPTH  7     minimum cycles between two issues of the same hart (PC to writeback)
//  RESET_MASK  8'h01 run mask after reset (hart 0 only)
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  en         in   1           issue enable; 0 forces a bubble this cycle
//  hart_wake  in   NUM_HARTS   one-hot/multi-hot pulses: set run bits
//  hart_park  in   NUM_HARTS   pulses: clear run bits
//  h_out      out  HART_W+1    {valid, hart_id}, registered, drives hart chain and PC enable
//  run_mask   out  NUM_HARTS   current runnable set
//  busy       out  NUM_HARTS   harts with an instruction in flight
//  idle       out  1           run_mask == 0 and busy == 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): h_out=0, run_mask=RESET_MASK, in-flight line cleared, busy=0, rr_ptr=NUM_HARTS-1.
//    Reset mid-operation discards all in-flight tracking; first issue possible on the cycle after rst falls.
//  - run_mask update per edge: next = (run_mask | hart_wake) & ~hart_park; park wins over wake on same bit.
//    Wake of a running hart / park of a parked hart: no effect.
//  - In-flight line: shift register of PIPE_DEPTH-1 entries {v,id}; entry 0 = current h_out, shifts every cycle
//    regardless of en. busy[i] = any valid entry with id i.
//  - Eligible[i] = run_mask[i] & ~busy[i] (current registered values; wake/park take effect next cycle).
//  - Pick: first eligible id searching rr_ptr+1, rr_ptr+2, ... mod NUM_HARTS. If en=1 and one found:
//    h_out <= {1,id}, rr_ptr <= id. Otherwise h_out <= {0, 0}, rr_ptr held.
//  - Latency: decision from state at cycle t appears on h_out at t+1; same hart issues at most once per PIPE_DEPTH cycles.
//  - Parking a busy hart: its in-flight instruction completes; no new issue. busy clears PIPE_DEPTH-1 cycles later.
//  - Bubbles carry valid=0 so downstream stage enables (PC, mem, reg-file writes) are gated off.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared package rv_pkg: NUM_HARTS, HART_W, PIPE_DEPTH, hart word layout (valid bit index, id field).
//  - Sub-module rv_rr_pick: combinational rotate-priority picker (req vector, ptr -> gnt_valid, gnt_id).
//  - Top holds run_mask reg, rr_ptr reg, in-flight shift line, h_out reg.
// TESTING
//  1. Reset, RESET_MASK=01, en=1 -> h_out valid id0 at cycle 1, bubbles cycles 2-7, id0 again cycle 8 (period 7).
//  2. wake=FF at cycle 0 -> ids 0,1,...,7,0,1 back-to-back with no bubbles; busy never shows issued id eligible.
//  3. run_mask=0F -> 0,1,2,3,bubble,bubble,bubble,0,1,... repeating every 7 cycles.
//  4. park=04 while hart 2 in flight -> no further id2; busy[2] clears 6 cycles after its issue; park=wake=02 same cycle -> run_mask[1]=0.
//  5. mask=FF, en=0 for 3 cycles after id3 issued -> 3 bubbles, then id4 (pointer held); in-flight line keeps shifting.
//  6. rst pulsed mid-stream with mask=FF -> next cycle h_out=0, run_mask=01, busy=0; following cycle id0.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared constants for the barrel-pipeline hart scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int              RV_NUM_HARTS  = 8;
    localparam int              RV_HART_W     = $clog2(RV_NUM_HARTS);
    localparam int              RV_PIPE_DEPTH = 7;
    localparam logic [7:0]      RV_RESET_MASK = 8'h01;

    // Hart slot word: {valid, hart_id}, valid in the MSB.
    localparam int              RV_SLOT_W         = RV_HART_W + 1;
    localparam int              RV_SLOT_VALID_BIT = RV_HART_W;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rv_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rv_rr_pick
//  Description : Combinational rotate-priority picker; first request after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_rr_pick #(
    parameter int NUM_HARTS = 8,
    parameter int HART_W    = 3
) (
    input  logic [NUM_HARTS-1:0] i_req,
    input  logic [HART_W-1:0]    i_ptr,
    output logic                 o_gnt_valid,
    output logic [HART_W-1:0]    o_gnt_id
);

    logic [HART_W-1:0] w_idx;

    // Search ptr+1 .. ptr+NUM_HARTS; modulo wrap comes free from the id width.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            w_idx = i_ptr + HART_W'(k);
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = w_idx;
            end
        end
    end

endmodule : rv_rr_pick
`default_nettype wire

// File: rtl/rv_hart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rv_hart_sched
//  Description : Dynamic round-robin hart scheduler with in-flight tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_hart_sched
    import rv_pkg::*;
#(
    parameter int                   NUM_HARTS  = RV_NUM_HARTS,
    parameter int                   HART_W     = $clog2(NUM_HARTS),
    parameter int                   PIPE_DEPTH = RV_PIPE_DEPTH,
    parameter logic [NUM_HARTS-1:0] RESET_MASK = NUM_HARTS'(RV_RESET_MASK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_HARTS-1:0] hart_wake,
    input  logic [NUM_HARTS-1:0] hart_park,
    output logic [HART_W:0]      h_out,
    output logic [NUM_HARTS-1:0] run_mask,
    output logic [NUM_HARTS-1:0] busy,
    output logic                 idle
);

    localparam int LINE_LEN = PIPE_DEPTH - 1;

    // r_line[0] is the issue register itself; older slots follow.
    logic [HART_W:0]      r_line [LINE_LEN];
    logic [NUM_HARTS-1:0] r_run_mask;
    logic [HART_W-1:0]    r_rr_ptr;

    logic [NUM_HARTS-1:0] w_busy;
    logic [NUM_HARTS-1:0] w_eligible;
    logic                 w_gnt_valid;
    logic [HART_W-1:0]    w_gnt_id;

    always_comb begin
        w_busy = '0;
        for (int k = 0; k < LINE_LEN; k++) begin
            if (r_line[k][HART_W]) begin
                w_busy[r_line[k][HART_W-1:0]] = 1'b1;
            end
        end
    end

    assign w_eligible = r_run_mask & ~w_busy;

    rv_rr_pick #(
        .NUM_HARTS (NUM_HARTS),
        .HART_W    (HART_W)
    ) u_pick (
        .i_req       (w_eligible),
        .i_ptr       (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_mask <= RESET_MASK;
            r_rr_ptr   <= HART_W'(NUM_HARTS - 1);
            for (int k = 0; k < LINE_LEN; k++) begin
                r_line[k] <= '0;
            end
        end else begin
            // Park wins over wake on the same bit.
            r_run_mask <= (r_run_mask | hart_wake) & ~hart_park;
            for (int k = 1; k < LINE_LEN; k++) begin
                r_line[k] <= r_line[k-1];
            end
            if (en && w_gnt_valid) begin
                r_line[0] <= {1'b1, w_gnt_id};
                r_rr_ptr  <= w_gnt_id;
            end else begin
                r_line[0] <= '0;
            end
        end
    end

    assign h_out    = r_line[0];
    assign run_mask = r_run_mask;
    assign busy     = w_busy;
    assign idle     = (r_run_mask == '0) && (w_busy == '0);

endmodule : rv_hart_sched
`default_nettype wire

// File: tb/tb_rv_hart_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_hart_sched
//  Description : Scoreboard bench for rv_hart_sched with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_hart_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] hart_wake = '0;
    logic [7:0] hart_park = '0;
    logic [3:0] h_out;
    logic [7:0] run_mask;
    logic [7:0] busy;
    logic       idle;

    rv_hart_sched dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .hart_wake (hart_wake),
        .hart_park (hart_park),
        .h_out     (h_out),
        .run_mask  (run_mask),
        .busy      (busy),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] h;
        logic [7:0] rm;
        logic [7:0] bz;
        logic       chk_rm;
        logic       chk_bz;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   inv_arm  = 1'b0;
    bit   done     = 1'b0;
    logic [7:0] prev_bz = '0;
    logic [7:0] prev_rm = '0;

    // Expected h_out sequences (0x8|id = valid issue, 0 = bubble).
    logic [3:0] t1_h  [8]  = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
    logic [7:0] t1_bz [8]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    logic [3:0] t2_h  [9]  = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h9};
    logic [3:0] t3_h  [14] = '{4'h9, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h8,
                               4'h9, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h8};
    logic [3:0] t4_h  [7]  = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h9, 4'h0, 4'hB};
    logic [3:0] t5_h  [5]  = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h8};

    task automatic step(input logic r, input logic e,
                        input logic [7:0] wk, input logic [7:0] pk,
                        input logic [3:0] eh, input logic [7:0] erm,
                        input logic [7:0] ebz, input logic crm, input logic cbz);
        exp_t x;
        rst = r; en = e; hart_wake = wk; hart_park = pk;
        @(posedge clk);
        x.h = eh; x.rm = erm; x.bz = ebz; x.chk_rm = crm; x.chk_bz = cbz;
        q.push_back(x);
        #1;
        rst = 1'b0; en = 1'b1; hart_wake = '0; hart_park = '0;
    endtask

    task automatic reset_step();
        step(1'b1, 1'b1, 8'h00, 8'h00, 4'h0, 8'h01, 8'h00, 1'b1, 1'b1);
    endtask

    // Monitor: pops one expectation per cycle and checks eligibility of every issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inv_arm && h_out[3] === 1'b1) begin
                n_checks++;
                if (prev_bz[h_out[2:0]] !== 1'b0 || prev_rm[h_out[2:0]] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL eligible: issued id %0d with prior busy=%h run_mask=%h, required runnable and not busy",
                             h_out[2:0], prev_bz, prev_rm);
                end
            end
            prev_bz = busy;
            prev_rm = run_mask;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (h_out !== e.h) begin
                    n_fail++;
                    $display("FAIL h_out @%0t: got %h, expected %h", $time, h_out, e.h);
                end
                if (e.chk_rm) begin
                    n_checks++;
                    if (run_mask !== e.rm) begin
                        n_fail++;
                        $display("FAIL run_mask @%0t: got %h, expected %h", $time, run_mask, e.rm);
                    end
                end
                if (e.chk_bz) begin
                    n_checks++;
                    if (busy !== e.bz) begin
                        n_fail++;
                        $display("FAIL busy @%0t: got %h, expected %h", $time, busy, e.bz);
                    end
                end
                if (e.chk_rm && e.chk_bz) begin
                    n_checks++;
                    if (idle !== (e.rm == 8'h00 && e.bz == 8'h00)) begin
                        n_fail++;
                        $display("FAIL idle @%0t: got %b, expected %b", $time, idle,
                                 (e.rm == 8'h00 && e.bz == 8'h00));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: bench did not finish, got running, expected done");
            $fatal(1, "timeout");
        end
    end

    initial begin
        // Reset mask 01: hart 0 issues with period 7.
        reset_step();
        inv_arm = 1'b1;
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, t1_h[i], 8'h01, t1_bz[i], 1'b1, 1'b1);

        // All harts awake: back-to-back issue with no bubbles.
        reset_step();
        step(1'b0, 1'b1, 8'hFF, 8'h00, 4'h8, 8'hFF, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, t2_h[i], 8'hFF, 8'h7E, 1'b1, (i == 5));

        // Mask 0F: four issues then three bubbles, repeating.
        reset_step();
        step(1'b0, 1'b1, 8'h0E, 8'h00, 4'h8, 8'h0F, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, t3_h[i], 8'h0F, 8'h0E, 1'b1, (i == 5));

        // Park hart 2 while in flight, then simultaneous park/wake of hart 1.
        reset_step();
        step(1'b0, 1'b1, 8'h0E, 8'h00, 4'h8, 8'h0F, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h9, 8'h0F, 8'h03, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'hA, 8'h0F, 8'h07, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h04, 4'hB, 8'h0B, 8'h0F, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, t4_h[i], 8'h0B,
                 (i == 3) ? 8'h0D : 8'h0B, 1'b1, (i == 3 || i == 4));
        step(1'b0, 1'b1, 8'h02, 8'h02, 4'h0, 8'h09, 8'h0B, 1'b1, 1'b1);

        // en low for three cycles after hart 3 issues: pointer held, line shifts.
        reset_step();
        step(1'b0, 1'b1, 8'hFF, 8'h00, 4'h8, 8'hFF, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h9, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'hA, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'hB, 8'hFF, 8'h0F, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'hFF, 8'h0E, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, t5_h[i], 8'hFF, 8'h00, 1'b1, 1'b0);

        // Reset pulsed mid-stream.
        reset_step();
        step(1'b0, 1'b1, 8'hFF, 8'h00, 4'h8, 8'hFF, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h9, 8'hFF, 8'h03, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'hA, 8'hFF, 8'h07, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h00, 8'h00, 4'h0, 8'h01, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h8, 8'h01, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h01, 8'h01, 1'b1, 1'b1);

        // Park the only hart: idle once its last instruction drains.
        reset_step();
        step(1'b0, 1'b1, 8'h00, 8'h01, 4'h8, 8'h00, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rv_hart_sched
`default_nettype wire
